// File: rtl/i2c_poll_sched.sv
// Round-robin poller that shares one 2-byte I2C read engine across NUM_SLOTS sensors,
// keeping the last good sample per slot and recovering the engine when it hangs.
module i2c_poll_sched #(
  parameter int NUM_SLOTS = 4,
  parameter int PERIOD    = 100000,
  parameter int GO_HOLD   = 4,
  parameter int TIMEOUT   = 4096,
  parameter int CNT_W     = 24
) (
  input  logic                   CLK,
  input  logic                   RESET_N,
  input  logic                   ENABLE,
  input  logic [NUM_SLOTS-1:0]   SLOT_MASK,
  input  logic [8*NUM_SLOTS-1:0] ADDR_TABLE,
  input  logic [7:0]             END_BYTE_CFG,
  output logic                   I2C_GO,
  output logic [7:0]             I2C_SLAVE_ADDRESS,
  output logic [7:0]             I2C_END_BYTE,
  output logic                   I2C_RST_N,
  input  logic                   I2C_END_OK,
  input  logic                   I2C_ACK_OK,
  input  logic [15:0]            I2C_DATA16,
  output logic [16*NUM_SLOTS-1:0] SAMPLE_DATA,
  output logic [NUM_SLOTS-1:0]   SAMPLE_VALID,
  output logic [NUM_SLOTS-1:0]   SAMPLE_ERR,
  output logic                   NEW_SAMPLE,
  output logic [2:0]             NEW_SLOT,
  output logic                   BUSY,
  output logic                   OVERRUN
);

  localparam int SW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

  typedef enum logic [2:0] {
    IDLE, SELECT, GO_HI, WAIT_START, WAIT_DONE, CAPTURE, RECOVER, NEXT
  } state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       periodCnt_q, periodCnt_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [2:0]             ptr_q, ptr_d;
  logic                   pending_q, pending_d;
  logic                   ackSticky_q, ackSticky_d;
  logic                   endOkPrev_q;
  logic                   tick;
  logic [3:0]             sel;
  logic [SW-1:0]          slotIdx;

  logic                   go_q, rstN_q, busy_q, overrun_q, newSample_q;
  logic [2:0]             newSlot_q;
  logic [7:0]             addr_q, endByte_q;
  logic [16*NUM_SLOTS-1:0] data_q;
  logic [NUM_SLOTS-1:0]   valid_q, err_q;

  // Returns {found, index} of the lowest set mask bit strictly above 'above'.
  function automatic logic [3:0] nextSet(input logic [NUM_SLOTS-1:0] mask, input int above);
    nextSet = 4'b0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--)
      if (mask[i] && i > above) nextSet = {1'b1, 3'(i)};
  endfunction

  assign slotIdx = ptr_q[SW-1:0];
  assign tick    = ENABLE && (periodCnt_q == CNT_W'(PERIOD - 1));

  always_comb begin
    periodCnt_d = '0;
    if (ENABLE && !tick) periodCnt_d = periodCnt_q + 1'b1;
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    ackSticky_d = ackSticky_q;
    pending_d   = pending_q;
    sel         = 4'b0;
    if (tick && state_q != IDLE) pending_d = 1'b1;
    case (state_q)
      IDLE: begin
        if (tick || (pending_q && ENABLE)) begin
          pending_d = 1'b0;
          if (SLOT_MASK != '0) begin
            sel     = nextSet(SLOT_MASK, -1);
            ptr_d   = sel[2:0];
            state_d = SELECT;
          end
        end
      end
      SELECT: begin
        ackSticky_d = 1'b0;
        cnt_d       = '0;
        state_d     = GO_HI;
      end
      GO_HI: begin
        if (cnt_q == CNT_W'(GO_HOLD - 1)) begin
          cnt_d   = '0;
          state_d = WAIT_START;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WAIT_START, WAIT_DONE: begin
        // The engine drops ACK_OK in the END_OK rise clock, so that clock is not sampled.
        if (state_q == WAIT_DONE && I2C_END_OK && !endOkPrev_q) begin
          state_d = CAPTURE;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          cnt_d   = '0;
          state_d = RECOVER;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (state_q == WAIT_START && !I2C_END_OK) state_d = WAIT_DONE;
          if (state_q == WAIT_DONE && I2C_ACK_OK) ackSticky_d = 1'b1;
        end
      end
      CAPTURE: state_d = NEXT;
      RECOVER: begin
        if (cnt_q == CNT_W'(2)) state_d = NEXT;
        else cnt_d = cnt_q + 1'b1;
      end
      NEXT: begin
        state_d = IDLE;
        if (ENABLE) begin
          sel = nextSet(SLOT_MASK, int'(ptr_q));
          if (sel[3]) begin
            ptr_d   = sel[2:0];
            state_d = SELECT;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (!ENABLE) pending_d = 1'b0;
  end

  // Outputs are registered from the next-state decode so they change cleanly with the state.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= IDLE;
      periodCnt_q <= '0;
      cnt_q       <= '0;
      ptr_q       <= '0;
      pending_q   <= 1'b0;
      ackSticky_q <= 1'b0;
      endOkPrev_q <= 1'b1;
      go_q        <= 1'b0;
      rstN_q      <= 1'b1;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
      newSample_q <= 1'b0;
      newSlot_q   <= '0;
      addr_q      <= '0;
      endByte_q   <= '0;
      data_q      <= '0;
      valid_q     <= '0;
      err_q       <= '0;
    end else begin
      state_q     <= state_d;
      periodCnt_q <= periodCnt_d;
      cnt_q       <= cnt_d;
      ptr_q       <= ptr_d;
      pending_q   <= pending_d;
      ackSticky_q <= ackSticky_d;
      endOkPrev_q <= I2C_END_OK;
      go_q        <= (state_d == GO_HI);
      rstN_q      <= !(state_d == RECOVER && cnt_d < CNT_W'(2));
      busy_q      <= !(state_d inside {IDLE, NEXT});
      overrun_q   <= tick && (state_q != IDLE);
      newSample_q <= 1'b0;
      if (state_q == SELECT) begin
        addr_q    <= ADDR_TABLE[8*slotIdx +: 8];
        endByte_q <= END_BYTE_CFG;
      end
      if (state_q == CAPTURE) begin
        newSample_q <= 1'b1;
        newSlot_q   <= ptr_q;
        if (ackSticky_q) begin
          data_q[16*slotIdx +: 16] <= I2C_DATA16;
          valid_q[slotIdx]         <= 1'b1;
          err_q[slotIdx]           <= 1'b0;
        end else begin
          err_q[slotIdx] <= 1'b1;
        end
      end
      if (state_q inside {WAIT_START, WAIT_DONE} && state_d == RECOVER) begin
        newSample_q    <= 1'b1;
        newSlot_q      <= ptr_q;
        err_q[slotIdx] <= 1'b1;
      end
    end
  end

  assign I2C_GO            = go_q;
  assign I2C_RST_N         = rstN_q;
  assign I2C_SLAVE_ADDRESS = addr_q;
  assign I2C_END_BYTE      = endByte_q;
  assign SAMPLE_DATA       = data_q;
  assign SAMPLE_VALID      = valid_q;
  assign SAMPLE_ERR        = err_q;
  assign NEW_SAMPLE        = newSample_q;
  assign NEW_SLOT          = newSlot_q;
  assign BUSY              = busy_q;
  assign OVERRUN           = overrun_q;

endmodule

// File: tb/tb_i2c_poll_sched.sv
// Scoreboard bench for i2c_poll_sched: a behavioural I2C engine answers launches,
// directed phases push expected samples, and a monitor checks each NEW_SAMPLE.
module tb_i2c_poll_sched;

  localparam int NUM_SLOTS = 4;
  localparam int PERIOD    = 50;
  localparam int GO_HOLD   = 4;
  localparam int TIMEOUT   = 64;

  logic        CLK, RESET_N, ENABLE;
  logic [3:0]  SLOT_MASK;
  logic [31:0] ADDR_TABLE;
  logic [7:0]  END_BYTE_CFG;
  logic        I2C_GO, I2C_RST_N, I2C_END_OK, I2C_ACK_OK;
  logic [7:0]  I2C_SLAVE_ADDRESS, I2C_END_BYTE;
  logic [15:0] I2C_DATA16;
  logic [63:0] SAMPLE_DATA;
  logic [3:0]  SAMPLE_VALID, SAMPLE_ERR;
  logic        NEW_SAMPLE, BUSY, OVERRUN;
  logic [2:0]  NEW_SLOT;

  i2c_poll_sched #(
    .NUM_SLOTS(NUM_SLOTS), .PERIOD(PERIOD), .GO_HOLD(GO_HOLD), .TIMEOUT(TIMEOUT), .CNT_W(24)
  ) dut (
    .CLK(CLK), .RESET_N(RESET_N), .ENABLE(ENABLE), .SLOT_MASK(SLOT_MASK),
    .ADDR_TABLE(ADDR_TABLE), .END_BYTE_CFG(END_BYTE_CFG), .I2C_GO(I2C_GO),
    .I2C_SLAVE_ADDRESS(I2C_SLAVE_ADDRESS), .I2C_END_BYTE(I2C_END_BYTE),
    .I2C_RST_N(I2C_RST_N), .I2C_END_OK(I2C_END_OK), .I2C_ACK_OK(I2C_ACK_OK),
    .I2C_DATA16(I2C_DATA16), .SAMPLE_DATA(SAMPLE_DATA), .SAMPLE_VALID(SAMPLE_VALID),
    .SAMPLE_ERR(SAMPLE_ERR), .NEW_SAMPLE(NEW_SAMPLE), .NEW_SLOT(NEW_SLOT),
    .BUSY(BUSY), .OVERRUN(OVERRUN)
  );

  typedef struct {
    int          slot;
    logic        err;
    logic [15:0] data;
    logic        valid;
  } exp_t;

  exp_t        sbQ[$];
  int          checks = 0;
  int          fails  = 0;
  bit          ackCfg[4];
  bit          hangCfg[4];
  logic [15:0] dataCfg[4];
  int          latency = 3;
  logic [7:0]  lastAddr = 8'h00;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic pushExp(input int slot, input logic err, input logic [15:0] data, input logic valid);
    exp_t e;
    e.slot = slot; e.err = err; e.data = data; e.valid = valid;
    sbQ.push_back(e);
  endtask

  task automatic applyStimulus(input logic [3:0] mask, input int lat, input logic [15:0] base,
                               input bit nackSlot2, input bit hangSlot1);
    SLOT_MASK = mask;
    latency   = lat;
    for (int i = 0; i < 4; i++) begin
      ackCfg[i]  = 1'b1;
      hangCfg[i] = 1'b0;
      dataCfg[i] = base + 16'(i);
    end
    if (nackSlot2) begin ackCfg[2] = 1'b0; dataCfg[2] = 16'hBEEF; end
    if (hangSlot1) hangCfg[1] = 1'b1;
  endtask

  // Counts NEW_SAMPLE pulses; drops ENABLE on the pulse that completes the phase.
  task automatic waitSamples(input int n, input int budget);
    int seen = 0;
    int cyc  = 0;
    while (seen < n && cyc < budget) begin
      @(negedge CLK);
      cyc++;
      if (NEW_SAMPLE) seen++;
    end
    ENABLE = 1'b0;
    checkOutput("phase_sample_count", seen, n);
  endtask

  task automatic runPhase(input int n, input int budget);
    ENABLE = 1'b1;
    waitSamples(n, budget);
    repeat (3) @(negedge CLK);
  endtask

  task automatic waitGo(input logic level, input int budget, output int n);
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (I2C_GO !== level && n < budget);
  endtask

  task automatic noGoCheck(input string name, input int cycles);
    int g = 0;
    repeat (cycles) begin
      @(negedge CLK);
      if (I2C_GO) g++;
    end
    checkOutput(name, g, 0);
  endtask

  // Behavioural engine: starts after GO falls, ACKs (or not), returns data, or hangs until reset.
  initial begin
    int width, slot, n, m;
    logic [7:0] addr;
    I2C_END_OK = 1'b1;
    I2C_ACK_OK = 1'b0;
    I2C_DATA16 = 16'h0000;
    forever begin
      @(negedge CLK);
      if (I2C_GO && RESET_N) begin
        width = 0;
        addr  = I2C_SLAVE_ADDRESS;
        while (I2C_GO && width < 64) begin
          width++;
          @(negedge CLK);
        end
        if (!RESET_N) continue;
        lastAddr = addr;
        checkOutput("go_width", width, GO_HOLD);
        slot = (int'(addr) - 128) / 2;
        if (slot < 0 || slot > 3) slot = 0;
        I2C_END_OK = 1'b0;
        if (hangCfg[slot]) begin
          n = 0;
          while (I2C_RST_N && n < 200) begin
            n++;
            @(negedge CLK);
          end
          checkOutput("timeout_clocks", n, TIMEOUT);
          I2C_END_OK = 1'b1;
          m = 0;
          while (!I2C_RST_N && m < 10) begin
            m++;
            @(negedge CLK);
          end
          checkOutput("rst_low_clocks", m, 2);
        end else begin
          for (int i = 1; i <= latency; i++) begin
            @(negedge CLK);
            if (i == 2) begin
              I2C_ACK_OK = ackCfg[slot];
              I2C_DATA16 = dataCfg[slot];
            end
          end
          I2C_END_OK = 1'b1;
          I2C_ACK_OK = 1'b0;
        end
      end
    end
  end

  // Monitor: every NEW_SAMPLE pulse is matched against the head of the scoreboard.
  initial begin
    exp_t e;
    int   s;
    forever begin
      @(negedge CLK);
      if (RESET_N && NEW_SAMPLE) begin
        if (sbQ.size() == 0) begin
          checkOutput("sb_depth", sbQ.size(), 1);
        end else begin
          e = sbQ.pop_front();
          s = e.slot;
          checkOutput("new_slot", NEW_SLOT, s);
          checkOutput("sample_err", SAMPLE_ERR[s], e.err);
          checkOutput("sample_data", SAMPLE_DATA[16*s +: 16], e.data);
          checkOutput("sample_valid", SAMPLE_VALID[s], e.valid);
          checkOutput("slave_addr", lastAddr, 8'h80 + 8'(2*s));
        end
      end
    end
  end

  initial begin
    int n, ovr, seen, cyc;
    RESET_N      = 1'b0;
    ENABLE       = 1'b0;
    SLOT_MASK    = 4'b0000;
    ADDR_TABLE   = 32'h86848280;
    END_BYTE_CFG = 8'h01;
    applyStimulus(4'b0000, 3, 16'h0000, 1'b0, 1'b0);
    repeat (3) @(negedge CLK);
    checkOutput("rst_go", I2C_GO, 0);
    checkOutput("rst_rst_n", I2C_RST_N, 1);
    checkOutput("rst_addr", I2C_SLAVE_ADDRESS, 0);
    checkOutput("rst_end_byte", I2C_END_BYTE, 0);
    checkOutput("rst_data", SAMPLE_DATA, 0);
    checkOutput("rst_valid", SAMPLE_VALID, 0);
    checkOutput("rst_err", SAMPLE_ERR, 0);
    checkOutput("rst_new_sample", NEW_SAMPLE, 0);
    checkOutput("rst_new_slot", NEW_SLOT, 0);
    checkOutput("rst_busy", BUSY, 0);
    checkOutput("rst_overrun", OVERRUN, 0);
    RESET_N = 1'b1;

    $display("[TB] empty mask");
    ENABLE = 1'b1;
    noGoCheck("no_go_empty_mask", 3 * PERIOD);
    ENABLE = 1'b0;
    repeat (2) @(negedge CLK);

    $display("[TB] happy path");
    applyStimulus(4'b1111, 3, 16'h1234, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) pushExp(i, 1'b0, 16'h1234 + 16'(i), 1'b1);
    runPhase(4, 400);
    checkOutput("happy_valid", SAMPLE_VALID, 4'hF);
    checkOutput("happy_data", SAMPLE_DATA, 64'h1237_1236_1235_1234);
    checkOutput("happy_end_byte", I2C_END_BYTE, 8'h01);
    checkOutput("happy_busy", BUSY, 0);
    noGoCheck("no_go_disabled", 60);

    $display("[TB] nack on slot 2");
    applyStimulus(4'b1111, 3, 16'h2000, 1'b1, 1'b0);
    pushExp(0, 1'b0, 16'h2000, 1'b1);
    pushExp(1, 1'b0, 16'h2001, 1'b1);
    pushExp(2, 1'b1, 16'h1236, 1'b1);
    pushExp(3, 1'b0, 16'h2003, 1'b1);
    runPhase(4, 400);
    checkOutput("nack_err", SAMPLE_ERR, 4'b0100);

    $display("[TB] hang on slot 1");
    applyStimulus(4'b1111, 3, 16'h3000, 1'b0, 1'b1);
    pushExp(0, 1'b0, 16'h3000, 1'b1);
    pushExp(1, 1'b1, 16'h2001, 1'b1);
    pushExp(2, 1'b0, 16'h3002, 1'b1);
    pushExp(3, 1'b0, 16'h3003, 1'b1);
    runPhase(4, 600);
    checkOutput("hang_err", SAMPLE_ERR, 4'b0010);
    checkOutput("hang_rst_n", I2C_RST_N, 1);

    $display("[TB] sparse mask with overrun");
    applyStimulus(4'b1010, 30, 16'h4000, 1'b0, 1'b0);
    pushExp(1, 1'b0, 16'h4001, 1'b1);
    pushExp(3, 1'b0, 16'h4003, 1'b1);
    pushExp(1, 1'b0, 16'h4001, 1'b1);
    pushExp(3, 1'b0, 16'h4003, 1'b1);
    ENABLE = 1'b1;
    ovr = 0; seen = 0; cyc = 0;
    while (seen < 2 && cyc < 400) begin
      @(negedge CLK);
      cyc++;
      if (OVERRUN) ovr++;
      if (NEW_SAMPLE) seen++;
    end
    checkOutput("overrun_pulses", ovr, 1);
    waitGo(1'b1, 20, n);
    checkOutput("restart_latency", n, 3);
    waitSamples(2, 400);
    repeat (3) @(negedge CLK);
    checkOutput("sparse_data", SAMPLE_DATA, 64'h4003_3002_4001_3000);
    checkOutput("sparse_err", SAMPLE_ERR, 4'b0000);

    $display("[TB] enable dropped during wait");
    applyStimulus(4'b1111, 10, 16'h5000, 1'b0, 1'b0);
    pushExp(0, 1'b0, 16'h5000, 1'b1);
    ENABLE = 1'b1;
    waitGo(1'b1, 3 * PERIOD, n);
    checkOutput("e_go_high", I2C_GO, 1);
    waitGo(1'b0, 20, n);
    checkOutput("e_go_low", I2C_GO, 0);
    repeat (3) @(negedge CLK);
    ENABLE = 1'b0;
    waitSamples(1, 100);
    repeat (2) @(negedge CLK);
    checkOutput("e_busy", BUSY, 0);
    checkOutput("e_period_cnt", dut.periodCnt_q, 0);
    noGoCheck("no_go_after_drop", 60);

    $display("[TB] reset during go");
    applyStimulus(4'b1111, 3, 16'h6000, 1'b0, 1'b0);
    ENABLE = 1'b1;
    waitGo(1'b1, 3 * PERIOD, n);
    @(negedge CLK);
    RESET_N = 1'b0;
    #1;
    checkOutput("r_go", I2C_GO, 0);
    checkOutput("r_data", SAMPLE_DATA, 0);
    checkOutput("r_valid", SAMPLE_VALID, 0);
    checkOutput("r_err", SAMPLE_ERR, 0);
    checkOutput("r_busy", BUSY, 0);
    repeat (3) @(negedge CLK);
    RESET_N = 1'b1;
    waitGo(1'b1, 3 * PERIOD, n);
    checkOutput("first_go_after_reset", n, PERIOD + 1);
    pushExp(0, 1'b0, 16'h6000, 1'b1);
    waitSamples(1, 100);
    repeat (3) @(negedge CLK);

    checkOutput("sb_empty", sbQ.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
